decode_buffer: RTL
==================

# decode_buffer

Parametrised decode stage with an elastic buffer between fetch and issue. It extracts register addresses, the destination register and the extended immediate from each fetched instruction. The decoded entry is stored in a DEPTH-entry FIFO and presented to issue through a valid/ready handshake. The FIFO replaces the single stall-gated pipeline register, so fetch keeps running while issue stalls, until the buffer is full. A synchronous flush drops all buffered entries on a redirect.

## Interface
- DATA_W, 32, instruction/PC/data width
- DEPTH, 4, buffer entries; power of two, ≥2
- REG_AW, 5, register address width
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived)

- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous discard of all entries
- if_valid  in  1  fetch presents an instruction
- if_instruc  in  DATA_W  instruction word
- if_nextpc  in  DATA_W  PC+4 of that instruction
- ctl_selregdest  in  1  from control: 1 = rd [15:11], 0 = rt [20:16]
- ctl_writereg  in  1  from control: instruction writes a register
- ctl_unsig  in  1  from control: zero-extend the immediate, else sign-extend
- id_if_ready  out  1  buffer can accept
- is_valid  out  1  head entry valid
- is_ready  in  1  issue accepts head
- is_instruc, is_nextpc  out  DATA_W  head instruction and next PC
- is_addra, is_addrb  out  REG_AW  rs [25:21], rt [20:16]
- is_regdest  out  REG_AW  selected destination
- is_writereg  out  1  head writes a register; forced 0 when !is_valid
- is_imedext  out  DATA_W  extended [15:0]
- count  out  CNT_W  occupancy

## Operation
- push = if_valid & id_if_ready; pop = is_valid & is_ready.
- id_if_ready = (count != DEPTH). There is no pass-through when full: push is refused even if a pop occurs in the same cycle.
- On push, the decoded entry is written at wr_ptr and wr_ptr increments mod DEPTH. On pop, rd_ptr increments mod DEPTH.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- is_valid = (count != 0). Head outputs read storage[rd_ptr] combinationally.
- Decode is combinational from if_instruc and ctl_*, captured at push:
  - regdest = selregdest ? [15:11] : [20:16].
  - imedext = unsig ? zero-extend [15:0] : sign-extend [15:0] to DATA_W.
- flush clears pointers and count. Flush beats push and pop in the same cycle: nothing is written, and the popped entry is still consumed by issue that cycle.
- Pushing when full or popping when empty cannot occur by construction; both must be asserted in the bench.

## Timing
- Reset (async, active-low): pointers=0, count=0, all storage=0. Outputs: id_if_ready=1, is_valid=0, is_writereg=0, count=0, all data outputs=0.
- Latency: an entry pushed in cycle N gives is_valid=1 in N+1. There is no same-cycle bypass.
- Throughput: 1 push and 1 pop per cycle while 0 < count < DEPTH.
- Full condition: count reaches DEPTH and id_if_ready drops in the next cycle. It returns to 1 the cycle after the first pop.
- flush in cycle N: count=0 and is_valid=0 in N+1, and id_if_ready=1.
- Reset asserted mid-stream: state clears immediately and buffered entries are lost.

## Structure
- Package decode_pkg holds:
  - typedef decoded_t {instruc, nextpc, addra, addrb, regdest, writereg, imedext};
  - the REG_AW constant;
  - the function ext_imm(imm16, unsig).
- Sub-module decode_fields: combinational mapping from instruction and ctl_* to decoded_t. It is reused by future dual-issue decode.
- Storage is a register array of decoded_t with no RAM macro, because it needs async reset.

## Test plan
- Reset then idle: id_if_ready=1, is_valid=0, count=0, and all outputs stay 0.
- Push 0x8C22FFFC (lw, selregdest=0, unsig=0), with is_ready=0. Next cycle: is_valid=1, is_addra=1, is_addrb=2, is_regdest=2, is_imedext=0xFFFFFFFC.
- Push 0x3422FFFC with unsig=1: is_imedext=0x0000FFFC. Push 0x00221820 (add, selregdest=1): is_regdest=3.
- is_ready=0 and push 5 instructions (DEPTH=4): four are accepted, id_if_ready=0 after the 4th, count=4. Then is_ready=1: the pops come out in FIFO order and id_if_ready=1 one cycle after the first pop.
- Steady push and pop at count=2 for 10 cycles: count stays 2, ordering is preserved, and the pointers wrap twice.
- flush with count=3 plus simultaneous push and pop: next cycle count=0, is_valid=0, is_writereg=0, and the pushed entry is not visible later.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode types for the fetch-to-issue boundary.
//   DATA_W    : instruction / PC / data width
//   REG_AW    : register address width
//   decoded_t : one decoded instruction as held in the issue buffer
//   ext_imm   : zero- or sign-extends a 16-bit immediate to DATA_W
package decode_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;

    typedef struct packed {
        logic [DATA_W-1:0] instruc;
        logic [DATA_W-1:0] nextpc;
        logic [REG_AW-1:0] addra;
        logic [REG_AW-1:0] addrb;
        logic [REG_AW-1:0] regdest;
        logic              writereg;
        logic [DATA_W-1:0] imedext;
    } decoded_t;

    function automatic logic [DATA_W-1:0] ext_imm(input logic [15:0] imm16, input logic unsig);
        logic [DATA_W-1:0] ext;
        if (unsig) begin
            ext = {{(DATA_W-16){1'b0}}, imm16};
        end else begin
            ext = {{(DATA_W-16){imm16[15]}}, imm16};
        end
        return ext;
    endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational field extraction for one instruction.
//   instruc    in  : instruction word
//   nextpc     in  : PC+4 of that instruction
//   selregdest in  : 1 selects rd [15:11] as destination, 0 selects rt [20:16]
//   writereg   in  : instruction writes a register
//   unsig      in  : zero-extend the immediate, else sign-extend
//   fields     out : decoded entry
module decode_fields
    import decode_pkg::*;
(
    input  logic [DATA_W-1:0] instruc,
    input  logic [DATA_W-1:0] nextpc,
    input  logic              selregdest,
    input  logic              writereg,
    input  logic              unsig,
    output decoded_t          fields
);

    always_comb begin
        fields          = '0;
        fields.instruc  = instruc;
        fields.nextpc   = nextpc;
        fields.addra    = instruc[25:21];
        fields.addrb    = instruc[20:16];
        fields.regdest  = selregdest ? instruc[15:11] : instruc[20:16];
        fields.writereg = writereg;
        fields.imedext  = ext_imm(instruc[15:0], unsig);
    end

endmodule

// File: rtl/decode_buffer.sv
// Decode stage with a DEPTH-entry elastic buffer between fetch and issue.
// Fetch keeps pushing while issue stalls until the buffer is full.
//   clock, reset (async, active-low), flush (sync discard of all entries)
//   if_valid / id_if_ready      : fetch handshake; if_instruc, if_nextpc, ctl_* decoded at push
//   is_valid / is_ready         : issue handshake; is_* present the head entry
//   count                       : current occupancy
// DATA_W and REG_AW must match the decode_pkg constants; the entry type is sized from them.
module decode_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_instruc,
    input  logic [DATA_W-1:0] if_nextpc,
    input  logic              ctl_selregdest,
    input  logic              ctl_writereg,
    input  logic              ctl_unsig,
    output logic              id_if_ready,
    output logic              is_valid,
    input  logic              is_ready,
    output logic [DATA_W-1:0] is_instruc,
    output logic [DATA_W-1:0] is_nextpc,
    output logic [REG_AW-1:0] is_addra,
    output logic [REG_AW-1:0] is_addrb,
    output logic [REG_AW-1:0] is_regdest,
    output logic              is_writereg,
    output logic [DATA_W-1:0] is_imedext,
    output logic [CNT_W-1:0]  count
);

    import decode_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);

    decoded_t             storage_q [DEPTH];
    decoded_t             push_entry;
    decoded_t             head;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 push, pop;

    decode_fields u_fields (
        .instruc    (if_instruc),
        .nextpc     (if_nextpc),
        .selregdest (ctl_selregdest),
        .writereg   (ctl_writereg),
        .unsig      (ctl_unsig),
        .fields     (push_entry)
    );

    // No pass-through when full: a same-cycle pop does not free a slot for the push.
    assign id_if_ready = (count_q != CNT_W'(DEPTH));
    assign is_valid    = (count_q != '0);
    assign push        = if_valid & id_if_ready;
    assign pop         = is_valid & is_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Register array rather than a RAM macro: entries must clear on async reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                storage_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push && !flush) begin
                storage_q[wr_ptr_q] <= push_entry;
            end
        end
    end

    assign head        = storage_q[rd_ptr_q];
    assign is_instruc  = head.instruc;
    assign is_nextpc   = head.nextpc;
    assign is_addra    = head.addra;
    assign is_addrb    = head.addrb;
    assign is_regdest  = head.regdest;
    assign is_writereg = head.writereg & is_valid;
    assign is_imedext  = head.imedext;
    assign count       = count_q;

endmodule
